// File: rtl/otter_intc_pkg.sv
// otter_intc_pkg: register map and shared types for the OTTER interrupt controller.
package otter_intc_pkg;

    // Register offsets from the controller base address
    localparam logic [31:0] INTC_PENDING  = 32'h0000_0000;
    localparam logic [31:0] INTC_ENABLE   = 32'h0000_0004;
    localparam logic [31:0] INTC_MODE     = 32'h0000_0008;
    localparam logic [31:0] INTC_CLAIM    = 32'h0000_000C;
    localparam logic [31:0] INTC_COMPLETE = 32'h0000_0010;

    // Size of the register window in bytes (five words)
    localparam logic [31:0] INTC_WINDOW   = 32'h0000_0014;

    // Source trigger mode as stored in the MODE register
    typedef enum logic {
        LEVEL = 1'b0,
        EDGE  = 1'b1
    } intc_mode_t;

endpackage

// File: rtl/intc_src_detect.sv
// intc_src_detect: per-source input conditioning for otter_intc.
// Optional 2-flop synchroniser when OTTER_INTC_SYNC_EN is defined, then a
// previous-sample flop that turns the conditioned level into a rise pulse.
module intc_src_detect (
    input  logic clk,
    input  logic rst,
    input  logic src,
    output logic level,
    output logic rise
);

    logic prev_r;

`ifdef OTTER_INTC_SYNC_EN
    logic sync1_r;
    logic sync2_r;

    // Two-stage synchroniser for an asynchronous request line
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= src;
            sync2_r <= sync1_r;
        end
    end

    assign level = sync2_r;
`else
    // Source is already synchronous to clk
    assign level = src;
`endif

    // Remember last sampled level so a 0->1 step can be recognised
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_r <= 1'b0;
        end else begin
            prev_r <= level;
        end
    end

    assign rise = level & ~prev_r;

endmodule

// File: rtl/otter_intc.sv
// otter_intc: prioritised, maskable interrupt controller on the OTTER IOBUS.
// Five-word register window: PENDING, ENABLE, MODE, CLAIM, COMPLETE.
// Define OTTER_INTC_SYNC_EN to put a 2-flop synchroniser on every source.
module otter_intc
    import otter_intc_pkg::*;
#(
    parameter int          NUM_SRC   = 8,
    parameter logic [31:0] BASE_ADDR = 32'h1100_0200
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [NUM_SRC-1:0] SRC_IN,
    input  logic [31:0]        IOBUS_ADDR,
    input  logic [31:0]        IOBUS_OUT,
    input  logic               IOBUS_WR,
    input  logic               INT_TAKEN,
    output logic [31:0]        RD_DATA,
    output logic               INTR
);

    logic [NUM_SRC-1:0] pending_r;
    logic [NUM_SRC-1:0] enable_r;
    logic [NUM_SRC-1:0] mode_r;
    logic               in_svc_r;
    logic [4:0]         active_id_r;

    logic [NUM_SRC-1:0] level_s;
    logic [NUM_SRC-1:0] rise_s;
    logic [NUM_SRC-1:0] cand_s;
    logic               cand_any_s;
    logic [4:0]         win_id_s;
    logic               take_s;
    logic [NUM_SRC-1:0] w1c_s;
    logic [NUM_SRC-1:0] claim_clr_s;
    logic [NUM_SRC-1:0] pending_nxt_s;

    logic [31:0]        off_s;
    logic               hit_s;
    logic [31:0]        rd_mux_s;
    logic               wr_pend_s;
    logic               wr_en_s;
    logic               wr_mode_s;
    logic               wr_cmpl_s;
    logic               unused_s;

    // Per-source conditioning: optional synchroniser and rise detection
    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        intc_src_detect u_det (
            .clk   (CLK),
            .rst   (RST),
            .src   (SRC_IN[g]),
            .level (level_s[g]),
            .rise  (rise_s[g])
        );
    end

    // Bits of the write data above the implemented sources are dropped
    assign unused_s = ^IOBUS_OUT[31:NUM_SRC];

    assign cand_s     = pending_r & enable_r;
    assign cand_any_s = |cand_s;
    assign INTR       = cand_any_s & ~in_svc_r;
    assign take_s     = INT_TAKEN & cand_any_s;

    // Find-first: lowest-index enabled pending source wins
    always_comb begin
        win_id_s = 5'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            win_id_s = cand_s[i] ? 5'(i) : win_id_s;
        end
    end

    assign off_s = IOBUS_ADDR - BASE_ADDR;
    assign hit_s = (off_s < INTC_WINDOW) && (off_s[1:0] == 2'b00);

    // Address decode: read mux and write strobes for the register window
    always_comb begin
        rd_mux_s  = 32'h0000_0000;
        wr_pend_s = 1'b0;
        wr_en_s   = 1'b0;
        wr_mode_s = 1'b0;
        wr_cmpl_s = 1'b0;
        if (hit_s) begin
            case (off_s)
                INTC_PENDING: begin
                    rd_mux_s  = 32'(pending_r);
                    wr_pend_s = IOBUS_WR;
                end
                INTC_ENABLE: begin
                    rd_mux_s = 32'(enable_r);
                    wr_en_s  = IOBUS_WR;
                end
                INTC_MODE: begin
                    rd_mux_s  = 32'(mode_r);
                    wr_mode_s = IOBUS_WR;
                end
                INTC_CLAIM: begin
                    rd_mux_s = in_svc_r ? 32'(active_id_r + 5'd1) : 32'h0000_0000;
                end
                INTC_COMPLETE: begin
                    wr_cmpl_s = IOBUS_WR;
                end
                default: begin
                    rd_mux_s = 32'h0000_0000;
                end
            endcase
        end else begin
            rd_mux_s = 32'h0000_0000;
        end
    end

    assign w1c_s       = wr_pend_s ? IOBUS_OUT[NUM_SRC-1:0] : {NUM_SRC{1'b0}};
    assign claim_clr_s = take_s ? (NUM_SRC'(1'b1) << win_id_s) : {NUM_SRC{1'b0}};

    // Next pending: edge bits hold until W1C or claim (a new rise wins); level bits track input
    always_comb begin
        pending_nxt_s = pending_r;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (intc_mode_t'(mode_r[i]) == EDGE) begin
                pending_nxt_s[i] = (pending_r[i] & ~w1c_s[i] & ~claim_clr_s[i]) | rise_s[i];
            end else begin
                pending_nxt_s[i] = level_s[i];
            end
        end
    end

    // Register file, service state and registered read data
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pending_r   <= {NUM_SRC{1'b0}};
            enable_r    <= {NUM_SRC{1'b0}};
            mode_r      <= {NUM_SRC{1'b0}};
            in_svc_r    <= 1'b0;
            active_id_r <= 5'd0;
            RD_DATA     <= 32'h0000_0000;
        end else begin
            pending_r <= pending_nxt_s;
            RD_DATA   <= rd_mux_s;
            if (wr_en_s) begin
                enable_r <= IOBUS_OUT[NUM_SRC-1:0];
            end
            if (wr_mode_s) begin
                mode_r <= IOBUS_OUT[NUM_SRC-1:0];
            end
            // A take in the same cycle as COMPLETE lands after it
            if (take_s) begin
                in_svc_r    <= 1'b1;
                active_id_r <= win_id_s;
            end else if (wr_cmpl_s) begin
                in_svc_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_otter_intc.sv
// tb_otter_intc: directed scoreboard bench for otter_intc (default NUM_SRC = 8).
module tb_otter_intc;

    localparam logic [31:0] BASE = 32'h1100_0200;
    localparam logic [31:0] A_PEND = BASE + 32'h00;
    localparam logic [31:0] A_EN   = BASE + 32'h04;
    localparam logic [31:0] A_MODE = BASE + 32'h08;
    localparam logic [31:0] A_CLM  = BASE + 32'h0C;
    localparam logic [31:0] A_CMPL = BASE + 32'h10;
`ifdef OTTER_INTC_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [7:0]  SRC_IN = 8'h00;
    logic [31:0] IOBUS_ADDR = 32'h0000_0000;
    logic [31:0] IOBUS_OUT = 32'h0000_0000;
    logic        IOBUS_WR = 1'b0;
    logic        INT_TAKEN = 1'b0;
    logic [31:0] RD_DATA;
    logic        INTR;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;
    exp_t sb_q[$];

    otter_intc #(.NUM_SRC(8), .BASE_ADDR(BASE)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .SRC_IN     (SRC_IN),
        .IOBUS_ADDR (IOBUS_ADDR),
        .IOBUS_OUT  (IOBUS_OUT),
        .IOBUS_WR   (IOBUS_WR),
        .INT_TAKEN  (INT_TAKEN),
        .RD_DATA    (RD_DATA),
        .INTR       (INTR)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Compare a 32-bit observation against a bench-computed value
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Register read: expectation queued with the address, popped when RD_DATA is valid
    task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string tag);
        exp_t e;
        exp_t got;
        IOBUS_ADDR = addr;
        IOBUS_WR   = 1'b0;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
        tick();
        got = sb_q.pop_front();
        check(got.tag, RD_DATA, got.exp);
        IOBUS_ADDR = 32'h0000_0000;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        IOBUS_ADDR = addr;
        IOBUS_OUT  = data;
        IOBUS_WR   = 1'b1;
        tick();
        IOBUS_WR   = 1'b0;
        IOBUS_ADDR = 32'h0000_0000;
    endtask

    task automatic take();
        INT_TAKEN = 1'b1;
        tick();
        INT_TAKEN = 1'b0;
    endtask

    // One-cycle pulse on the given sources, then wait out the synchroniser
    task automatic pulse(input logic [7:0] mask);
        SRC_IN = SRC_IN | mask;
        tick();
        SRC_IN = SRC_IN & ~mask;
        repeat (LAT) tick();
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        RST = 1'b0;
        tick();
        check("rst_intr", {31'd0, INTR}, 32'd0);
        rd(A_PEND, 32'h0, "rst_pending");
        rd(A_EN,   32'h0, "rst_enable");
        rd(A_MODE, 32'h0, "rst_mode");
        rd(A_CLM,  32'h0, "rst_claim");

        // Upper bits ignored; outside-window accesses have no effect
        wr(A_EN, 32'hFFFF_FF05);
        wr(A_MODE, 32'h0000_0005);
        rd(A_EN, 32'h0000_0005, "enable_mask");
        wr(BASE + 32'h14, 32'h0000_00FF);
        rd(BASE + 32'h14, 32'h0, "out_of_window_rd");
        rd(A_EN, 32'h0000_0005, "out_of_window_wr");
        rd(A_MODE, 32'h0000_0005, "mode_rd");

        // Single edge source 2
        SRC_IN = 8'h04;
        tick();
        SRC_IN = 8'h00;
        for (int k = 0; k < LAT; k++) begin
            check("intr_sync_latency", {31'd0, INTR}, 32'd0);
            tick();
        end
        check("edge2_intr", {31'd0, INTR}, 32'd1);
        rd(A_PEND, 32'h04, "edge2_pending");
        take();
        check("take2_intr", {31'd0, INTR}, 32'd0);
        rd(A_CLM, 32'd3, "take2_claim");
        rd(A_PEND, 32'h0, "take2_pending");
        wr(A_CMPL, 32'h0);
        rd(A_CLM, 32'd0, "complete2_claim");

        // Two simultaneous edges: lowest index first
        pulse(8'h05);
        check("dual_intr", {31'd0, INTR}, 32'd1);
        take();
        rd(A_CLM, 32'd1, "dual_claim0");
        rd(A_PEND, 32'h04, "dual_pending");
        wr(A_CMPL, 32'h0);
        check("dual_reintr", {31'd0, INTR}, 32'd1);
        take();
        rd(A_CLM, 32'd3, "dual_claim2");
        wr(A_CMPL, 32'h0);
        rd(A_PEND, 32'h0, "dual_pending_clr");

        // Level source 1
        wr(A_EN, 32'h07);
        SRC_IN = 8'h02;
        tick();
        repeat (LAT) tick();
        check("lvl_intr", {31'd0, INTR}, 32'd1);
        take();
        check("lvl_take_intr", {31'd0, INTR}, 32'd0);
        rd(A_CLM, 32'd2, "lvl_claim");
        wr(A_CMPL, 32'h0);
        check("lvl_after_complete", {31'd0, INTR}, 32'd1);
        wr(A_PEND, 32'h02);
        rd(A_PEND, 32'h02, "lvl_w1c_ignored");
        SRC_IN = 8'h00;
        tick();
        repeat (LAT) tick();
        check("lvl_drop_intr", {31'd0, INTR}, 32'd0);
        rd(A_PEND, 32'h0, "lvl_drop_pending");

        // W1C alone clears; W1C with a coincident rise keeps the bit
        pulse(8'h04);
        rd(A_PEND, 32'h04, "w1c_pre");
        wr(A_PEND, 32'h04);
        rd(A_PEND, 32'h0, "w1c_clears");
        pulse(8'h04);
        rd(A_PEND, 32'h04, "w1c_race_pre");
        SRC_IN = 8'h04;
        repeat (LAT) tick();
        wr(A_PEND, 32'h04);
        SRC_IN = 8'h00;
        rd(A_PEND, 32'h04, "w1c_race_set_wins");

        // Claim-clear with a coincident rise keeps the bit
        SRC_IN = 8'h04;
        repeat (LAT) tick();
        take();
        SRC_IN = 8'h00;
        rd(A_CLM, 32'd3, "claim_race_claim");
        rd(A_PEND, 32'h04, "claim_race_set_wins");

        // COMPLETE and INT_TAKEN together: service continues with the new winner
        pulse(8'h01);
        IOBUS_ADDR = A_CMPL;
        IOBUS_OUT  = 32'h0;
        IOBUS_WR   = 1'b1;
        INT_TAKEN  = 1'b1;
        tick();
        IOBUS_WR   = 1'b0;
        INT_TAKEN  = 1'b0;
        IOBUS_ADDR = 32'h0;
        rd(A_CLM, 32'd1, "cmpl_take_claim");
        rd(A_PEND, 32'h04, "cmpl_take_pending");

        // Asynchronous reset while in service with PENDING = 0x03
        wr(A_MODE, 32'h07);
        wr(A_PEND, 32'h04);
        pulse(8'h03);
        rd(A_CLM, 32'd1, "pre_rst_claim");
        rd(A_PEND, 32'h03, "pre_rst_pending");
        #2;
        RST = 1'b1;
        #1;
        check("async_rst_rd_data", RD_DATA, 32'h0);
        check("async_rst_intr", {31'd0, INTR}, 32'd0);
        tick();
        RST = 1'b0;
        tick();
        rd(A_PEND, 32'h0, "post_rst_pending");
        rd(A_EN,   32'h0, "post_rst_enable");
        rd(A_MODE, 32'h0, "post_rst_mode");
        rd(A_CLM,  32'h0, "post_rst_claim");
        check("post_rst_intr", {31'd0, INTR}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
